// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: single-cycle hold/shift/rotate/load/clear/asr,
// plus a sequencer that repeats a shift or rotate 'amount' times from one start command.
module universal_shift_reg #(
   parameter int                 WIDTH   = 8,
   parameter logic [WIDTH-1:0]   RST_VAL = '0,
   localparam int                CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [2:0]        mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              sin_l,
   input  logic              sin_r,
   input  logic              start,
   input  logic [CNT_W-1:0]  amount,
   output logic [WIDTH-1:0]  q,
   output logic              sout_l,
   output logic              sout_r,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHL   = 3'b001;
   localparam logic [2:0] MODE_SHR   = 3'b010;
   localparam logic [2:0] MODE_ROL   = 3'b011;
   localparam logic [2:0] MODE_ROR   = 3'b100;
   localparam logic [2:0] MODE_LOAD  = 3'b101;
   localparam logic [2:0] MODE_CLEAR = 3'b110;
   localparam logic [2:0] MODE_ASR   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   q_q, q_d;

   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] din,
      input logic             sl,
      input logic             sr
   );
      case (op)
         MODE_SHL:   apply_op = {cur[WIDTH-2:0], sr};
         MODE_SHR:   apply_op = {sl, cur[WIDTH-1:1]};
         MODE_ROL:   apply_op = {cur[WIDTH-2:0], cur[WIDTH-1]};
         MODE_ROR:   apply_op = {cur[0], cur[WIDTH-1:1]};
         MODE_LOAD:  apply_op = din;
         MODE_CLEAR: apply_op = '0;
         MODE_ASR:   apply_op = {cur[WIDTH-1], cur[WIDTH-1:1]};
         default:    apply_op = cur;
      endcase
   endfunction

   // Only shifts and rotates are meaningful to repeat; anything else finishes immediately.
   function automatic logic is_repeatable(input logic [2:0] op);
      is_repeatable = (op == MODE_SHL) || (op == MODE_SHR) || (op == MODE_ROL) ||
                      (op == MODE_ROR) || (op == MODE_ASR);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= MODE_HOLD;
         cnt_q   <= '0;
         q_q     <= RST_VAL;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
      end
   end

   // Accepting a start never moves q; the first step happens on the next enabled edge.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = mode;
               cnt_d = amount;
               if (amount == '0 || !is_repeatable(mode)) state_d = DONE;
               else                                      state_d = RUN;
            end else if (en) begin
               q_d = apply_op(mode, q_q, d, sin_l, sin_r);
            end
         end
         RUN: begin
            if (en) begin
               q_d   = apply_op(op_q, q_q, d, sin_l, sin_r);
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (en) q_d = apply_op(mode, q_q, d, sin_l, sin_r);
         end
         default: state_d = IDLE;
      endcase
   end

   assign q      = q_q;
   assign sout_l = q_q[WIDTH-1];
   assign sout_r = q_q[0];
   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg (WIDTH=8, RST_VAL=A5): directed scenarios followed by
// a randomized run compared against an arithmetic model of the register and sequencer.
module tb_universal_shift_reg;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic [2:0]        mode = 3'b000;
   logic [WIDTH-1:0]  d = '0;
   logic              sin_l = 1'b0;
   logic              sin_r = 1'b0;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  amount = '0;
   logic [WIDTH-1:0]  q;
   logic              sout_l, sout_r, busy, done;

   int checks = 0;
   int errors = 0;

   universal_shift_reg #(.WIDTH(WIDTH), .RST_VAL(8'hA5)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
      .start(start), .amount(amount), .q(q), .sout_l(sout_l), .sout_r(sout_r),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference operation using plain integer arithmetic on the 8-bit value.
   function automatic logic [7:0] ref_op(input logic [2:0] m, input logic [7:0] v,
                                         input logic [7:0] dd, input logic sl, input logic sr);
      int x;
      x = int'(v);
      case (m)
         3'd1:    return 8'((x * 2 + int'(sr)) % 256);
         3'd2:    return 8'(x / 2 + int'(sl) * 128);
         3'd3:    return 8'((x * 2) % 256 + x / 128);
         3'd4:    return 8'(x / 2 + (x % 2) * 128);
         3'd5:    return dd;
         3'd6:    return 8'd0;
         3'd7:    return 8'(x / 2 + (x / 128) * 128);
         default: return v;
      endcase
   endfunction

   task automatic load_value(input logic [7:0] v);
      start = 0; en = 1; mode = 3'b101; d = v;
      tick();
      mode = 3'b000;
   endtask

   task automatic test_reset();
      rst = 1; en = 1'($urandom); mode = 3'($urandom); start = 1'($urandom); amount = 4'($urandom);
      tick();
      checks++;
      if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: q=%h busy=%b done=%b, expected q=a5 busy=0 done=0", q, busy, done);
      end
      start = 0; en = 1; mode = 3'b101; d = 8'hFF;
      tick();
      checks++;
      if (q !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL reset_priority: q=%h expected a5", q);
      end
      rst = 0; mode = 3'b000;
   endtask

   task automatic test_load_hold();
      load_value(8'hB4);
      checks++;
      if (q !== 8'hB4) begin errors++; $display("[TB] FAIL load: q=%h expected b4", q); end
      en = 1; mode = 3'b000;
      tick();
      checks++;
      if (q !== 8'hB4) begin errors++; $display("[TB] FAIL hold_mode: q=%h expected b4", q); end
      en = 0; mode = 3'b101; d = 8'hFF;
      tick();
      checks++;
      if (q !== 8'hB4) begin errors++; $display("[TB] FAIL hold_en0: q=%h expected b4", q); end
      en = 1; mode = 3'b000;
   endtask

   task automatic test_single_ops();
      logic [2:0] ops [6];
      logic [7:0] exps [6];
      ops  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd6};
      exps = '{8'h69, 8'h5A, 8'h69, 8'h5A, 8'hDA, 8'h00};
      for (int i = 0; i < 6; i++) begin
         load_value(8'hB4);
         sin_l = 0; sin_r = 1; en = 1; mode = ops[i];
         tick();
         mode = 3'b000;
         checks++;
         if (q !== exps[i] || sout_r !== exps[i][0] || sout_l !== exps[i][7]) begin
            errors++;
            $display("[TB] FAIL single_op mode=%0d: q=%h sl=%b sr=%b expected %h", ops[i], q, sout_l, sout_r, exps[i]);
         end
      end
   endtask

   task automatic test_multi_step();
      logic [7:0] seq [3];
      seq = '{8'h03, 8'h06, 8'h0C};
      load_value(8'h81);
      start = 1; mode = 3'b011; amount = 3; en = 1;
      tick();
      start = 0; mode = 3'b000;
      checks++;
      if (q !== 8'h81 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL multi_accept: q=%h busy=%b done=%b expected 81/1/0", q, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q !== seq[i] || busy !== (i < 2) || done !== (i == 2)) begin
            errors++;
            $display("[TB] FAIL multi_step%0d: q=%h busy=%b done=%b expected %h/%b/%b",
                     i, q, busy, done, seq[i], i < 2, i == 2);
         end
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h0C) begin
         errors++;
         $display("[TB] FAIL multi_after: q=%h busy=%b done=%b expected 0c/0/0", q, busy, done);
      end
      start = 1; mode = 3'b011; amount = 0;
      tick();
      start = 0; mode = 3'b000;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h0C) begin
         errors++;
         $display("[TB] FAIL amount_zero: q=%h busy=%b done=%b expected 0c/0/1", q, busy, done);
      end
      tick();
      start = 1; mode = 3'b101; amount = 3; d = 8'hFF;
      tick();
      start = 0; mode = 3'b000;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h0C) begin
         errors++;
         $display("[TB] FAIL start_load: q=%h busy=%b done=%b expected 0c/0/1", q, busy, done);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL start_load_end: busy=%b done=%b expected 0/0", busy, done);
      end
   endtask

   task automatic test_stall_ignore();
      load_value(8'h81);
      start = 1; mode = 3'b011; amount = 3; en = 1;
      tick();
      start = 0; mode = 3'b000;
      tick();
      en = 0;
      for (int i = 0; i < 2; i++) begin
         start = 1; mode = 3'b101; d = 8'hFF; amount = 1;
         tick();
         checks++;
         if (q !== 8'h03 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall%0d: q=%h busy=%b done=%b expected 03/1/0", i, q, busy, done);
         end
      end
      start = 0; mode = 3'b000; en = 1;
      tick();
      checks++;
      if (q !== 8'h06 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_resume: q=%h busy=%b expected 06/1", q, busy);
      end
      tick();
      checks++;
      if (q !== 8'h0C || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_done: q=%h busy=%b done=%b expected 0c/0/1", q, busy, done);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      load_value(8'h81);
      start = 1; mode = 3'b011; amount = 5; en = 1;
      tick();
      start = 0; mode = 3'b000;
      tick();
      tick();
      checks++;
      if (q !== 8'h06) begin errors++; $display("[TB] FAIL midrun_pre: q=%h expected 06", q); end
      rst = 1;
      tick();
      rst = 0;
      checks++;
      if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrun_reset: q=%h busy=%b done=%b expected a5/0/0", q, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || q !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL midrun_after%0d: q=%h busy=%b done=%b expected a5/0/0", i, q, busy, done);
         end
      end
   endtask

   // Model: steps_left>0 means a repeated op is in flight; done_due marks the finishing cycle.
   task automatic test_random();
      logic [7:0] m_q;
      logic [2:0] m_op;
      int         steps_left;
      logic       done_due;
      logic       was_done;
      m_q = 8'h00; m_op = 3'b000; steps_left = 0; done_due = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst    = (cyc == 0) || ($urandom_range(0, 39) == 0);
         en     = ($urandom_range(0, 3) != 0);
         mode   = 3'($urandom);
         d      = 8'($urandom);
         sin_l  = 1'($urandom);
         sin_r  = 1'($urandom);
         start  = ($urandom_range(0, 3) == 0);
         amount = 4'($urandom_range(0, 10));
         if (rst) begin
            m_q = 8'hA5; steps_left = 0; done_due = 0;
         end else if (steps_left > 0) begin
            if (en) begin
               m_q = ref_op(m_op, m_q, d, sin_l, sin_r);
               steps_left--;
               done_due = (steps_left == 0);
            end
         end else begin
            was_done = done_due;
            done_due = 0;
            if (!was_done && start) begin
               m_op = mode;
               if (amount == 0 || mode == 3'd0 || mode == 3'd5 || mode == 3'd6) done_due = 1;
               else steps_left = int'(amount);
            end else if (en) begin
               m_q = ref_op(mode, m_q, d, sin_l, sin_r);
            end
         end
         tick();
         checks++;
         if (q !== m_q || busy !== (steps_left > 0) || done !== done_due ||
             sout_l !== m_q[7] || sout_r !== m_q[0]) begin
            errors++;
            $display("[TB] FAIL random cyc=%0d: q=%h busy=%b done=%b sl=%b sr=%b expected q=%h busy=%b done=%b",
                     cyc, q, busy, done, sout_l, sout_r, m_q, steps_left > 0, done_due);
         end
      end
      rst = 0; start = 0; en = 0;
   endtask

   initial begin
      test_reset();
      test_load_hold();
      test_single_ops();
      test_multi_step();
      test_stall_ignore();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
